// File: rtl/fft_peak_hold_pkg.sv
// Shared constants and clear-FSM state type for the spectrum display path.
package fft_disp_pkg;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_NUM_BINS    = 512;
  localparam int DEF_DECAY_SHIFT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;
endpackage

// File: rtl/fft_peak_hold_if.sv
// Magnitude stream from the FFT plus the display read port.
interface fft_peak_hold_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BINS   = 512
) ();
  localparam int ADDR_W = $clog2(NUM_BINS);

  logic [2*DATA_WIDTH-1:0] mag_squared;
  logic                    mag_valid;
  logic                    mag_last;
  logic [ADDR_W-1:0]       rd_addr;
  logic [2*DATA_WIDTH-1:0] rd_data;

  modport master (output mag_squared, mag_valid, mag_last, rd_addr, input rd_data);
  modport slave  (input mag_squared, mag_valid, mag_last, rd_addr, output rd_data);
endinterface

// File: rtl/fft_peak_hold_bram.sv
// One write port, two synchronous read ports, read-first on collisions.
module spectrum_bram #(
  parameter int W     = 32,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);
  logic [W-1:0] mem [DEPTH];

  // Write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered reads see the pre-write contents of the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end
endmodule

// File: rtl/fft_peak_hold.sv
// Decaying per-bin peak hold with frame peak search and a clear sweep.
module fft_peak_hold
  import fft_disp_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_BINS    = DEF_NUM_BINS,
  parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  fft_peak_hold_if.slave            bus,
  output logic                      busy,
  output logic                      frame_done,
  output logic [$clog2(NUM_BINS)-1:0] peak_bin,
  output logic [2*DATA_WIDTH-1:0]   peak_val
);
  localparam int ADDR_W = $clog2(NUM_BINS);
  localparam int MW     = 2*DATA_WIDTH;
  localparam int CW     = ADDR_W + 1;  // covers frames up to 2*NUM_BINS

  clr_state_e        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [CW-1:0]     wr_bin;

  logic              s1_wr, s1_last;
  logic [ADDR_W-1:0] s1_addr;
  logic [MW-1:0]     s1_mag, old_val, dec_val, new_val;

  logic [MW-1:0]     run_val, cand_val;
  logic [ADDR_W-1:0] run_bin, cand_bin;

  logic accept, in_range, clr_wr, ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [MW-1:0]     ram_wdata;

  assign busy     = (state == CLEAR);
  // A clear on this edge also blocks the sample so no S1 write overlaps the sweep.
  assign accept   = bus.mag_valid && !busy && !clear;
  assign in_range = ~wr_bin[CW-1];
  assign clr_wr   = busy && !clear;

  // dec <= old, so the subtraction cannot underflow.
  assign dec_val  = old_val - (old_val >> DECAY_SHIFT);
  assign new_val  = (s1_mag > dec_val) ? s1_mag : dec_val;

  // Strictly greater replaces, so ties keep the lowest bin.
  assign cand_val = (s1_wr && s1_mag > run_val) ? s1_mag  : run_val;
  assign cand_bin = (s1_wr && s1_mag > run_val) ? s1_addr : run_bin;

  assign ram_we    = clr_wr || s1_wr;
  assign ram_waddr = clr_wr ? clr_addr : s1_addr;
  assign ram_wdata = clr_wr ? '0 : new_val;

  spectrum_bram #(.W(MW), .DEPTH(NUM_BINS), .AW(ADDR_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (wr_bin[ADDR_W-1:0]),
    .rdata_a (old_val),
    .raddr_b (bus.rd_addr),
    .rdata_b (bus.rd_data)
  );

  // Clear sweep: reset release and every clear pulse restart at address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else if (clear) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == ADDR_W'(NUM_BINS-1)) state <= IDLE;
    end
  end

  // Bin counter; saturates on over-long frames so nothing past it is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                wr_bin <= '0;
    else if (busy || clear)  wr_bin <= '0;
    else if (bus.mag_valid) begin
      if (bus.mag_last)             wr_bin <= '0;
      else if (wr_bin != {CW{1'b1}}) wr_bin <= wr_bin + 1'b1;
    end
  end

  // S0 -> S1 register: sample, address and frame-end flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_wr   <= 1'b0;
      s1_last <= 1'b0;
      s1_addr <= '0;
      s1_mag  <= '0;
    end else begin
      s1_wr   <= accept && in_range;
      s1_last <= accept && bus.mag_last;
      s1_addr <= wr_bin[ADDR_W-1:0];
      s1_mag  <= bus.mag_squared;
    end
  end

  // Running frame peak; latched out and restarted at the last bin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_val    <= '0;
      run_bin    <= '0;
      peak_val   <= '0;
      peak_bin   <= '0;
      frame_done <= 1'b0;
    end else if (busy || clear) begin
      run_val    <= '0;
      run_bin    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= s1_last;
      if (s1_last) begin
        peak_val <= cand_val;
        peak_bin <= cand_bin;
        run_val  <= '0;
        run_bin  <= '0;
      end else begin
        run_val  <= cand_val;
        run_bin  <= cand_bin;
      end
    end
  end
endmodule
